branch_predictor: RTL and testbench
===================================

# branch_predictor

- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Predicts next-PC redirection for each fetched PC, one cycle after lookup.
- Trained by the execute stage with the resolved outcome of every branch or jump. This is the same taken/not-taken decision that drives `pc_sel`.
- Sits between the PC generator (lookup side) and branch resolution in execute (update side).

## Interface
- `AW`, 32, address/PC width
- `ENTRIES`, 64, BTB depth; power of two, at least 2
- `clk`  input  1  clock
- `rst_n`  input  1  asynchronous active-low reset
- `lu_valid`  input  1  lookup request this cycle
- `lu_pc`  input  AW  PC being fetched
- `pred_valid`  output  1  prediction result valid; corresponds to the lookup of the previous cycle
- `pred_taken`  output  1  predict redirect
- `pred_target`  output  AW  predicted target; 0 when `pred_taken`=0
- `upd_valid`  input  1  resolved control-transfer instruction
- `upd_pc`  input  AW  PC of that instruction
- `upd_taken`  input  1  resolved outcome; 1 for jal/jalr
- `upd_is_jump`  input  1  instruction is jal/jalr
- `upd_target`  input  AW  resolved target address

## Operation
- **Address fields**
  - IDX_W = log2(ENTRIES).
  - Index = pc[IDX_W+1:2].
  - Tag = pc[AW-1:IDX_W+2].
  - pc[1:0] is ignored.
- **Per-entry state:** valid bit, tag, target (AW bits), 2-bit counter `ctr`.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup** (registered when `lu_valid`=1)
  - Hit = valid and tag match.
  - `pred_taken` = hit and ctr[1].
  - `pred_target` = entry target if `pred_taken`, else 0.
- **Update when `upd_valid`=1**
  - Miss, `upd_taken`=1: allocate the entry.
    - valid=1, tag and target written.
    - ctr=11 if `upd_is_jump`, else 10.
  - Miss, `upd_taken`=0: no allocation; state unchanged.
  - Hit: target rewritten only when `upd_taken`=1.
    - `upd_is_jump`=1: ctr forced to 11.
    - Otherwise ctr is incremented if taken, decremented if not.
    - ctr saturates at 11 and at 00.
  - A valid entry is never invalidated except by reset.
- **Same cycle, same index** for lookup and update: the lookup sees the pre-update state (no bypass). The update commits.
- **Reset** (asynchronous assert, synchronous deassert handled externally):
  - All valid bits cleared, all ctr set to 01, tags and targets set to 0.
  - `pred_valid`=0, `pred_taken`=0, `pred_target`=0.
- **Reset asserted mid-operation:** the in-flight lookup result is discarded and any concurrent update is lost.

## Timing
- **Lookup latency:** exactly 1 cycle.
  - A lookup presented at edge N produces `pred_*` valid after edge N+1.
  - Outputs hold until the next edge.
- If `lu_valid`=0, the next cycle shows `pred_valid`=0, `pred_taken`=0, `pred_target`=0.
- One lookup and one update are accepted per cycle. There is no backpressure and no ready signal.
- An update at edge N is visible to lookups presented at edge N+1 or later.
- There are no combinational paths from inputs to outputs.

## Structure
- **Shared core package** holds:
  - the `ctr_t` 2-bit typedef;
  - constants `CTR_SNT`=00, `CTR_WNT`=01, `CTR_WT`=10, `CTR_ST`=11;
  - a `bp_update_t` struct bundling the `upd_*` fields.
- **One sub-module:** `sat_ctr2`, a combinational next-state function for the counter.
  - Inputs: current ctr, taken, force_strong.
  - Output: next ctr.
- Storage uses flop arrays, not SRAM, because of the asynchronous full reset.

## Test plan
- **Reset:** drive `rst_n`=0 mid-stream, then look up 0x0000_0100.
  - Requires `pred_valid`=0 during reset.
  - After release, `pred_taken`=0 and `pred_target`=0.
- **Allocate-on-taken:** update pc 0x100, taken=1, target 0x200, is_jump=0, then look up 0x100.
  - Requires one cycle later `pred_taken`=1 and `pred_target`=0x200.
- **Hysteresis:** starting from the previous scenario (ctr=10), apply three not-taken updates to 0x100, looking up after each.
  - Requires predictions 0, 0, 0.
  - Then one taken update gives ctr 01 and prediction 0.
  - A second taken update gives prediction 1.
- **Saturation and jump:** apply five taken updates to 0x300 (target 0x400), then one not-taken.
  - Requires the prediction to stay 1.
  - A jump update to 0x500 (target 0x600) followed by a lookup gives `pred_taken`=1, `pred_target`=0x600.
- **Aliasing:** with ENTRIES=64, allocate 0x100, then allocate 0x200 taken with target 0x900; the two PCs share an index.
  - Requires a lookup of 0x100 to miss (`pred_taken`=0).
  - Requires a lookup of 0x200 to give target 0x900.
- **Same-cycle collision:** present a lookup of 0x100 together with the first taken update of 0x100.
  - Requires `pred_taken`=0 for that lookup.
  - Requires a lookup on the next cycle to give `pred_taken`=1.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter and update types for the branch predictor
package branch_predictor_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Control flags of a resolved branch; pc and target stay AW-parameterised on the top.
  typedef struct packed {
    logic valid;
    logic taken;
    logic is_jump;
  } bp_update_t;

endpackage

// File: rtl/sat_ctr2.sv
// rtl/sat_ctr2.sv - next-state function of a 2-bit saturating branch counter
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  input  logic force_strong,
  output ctr_t ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (force_strong) begin
      ctr_nxt = CTR_ST;
    end else if (taken) begin
      if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, one-cycle registered prediction
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int AW      = 32,
  parameter int ENTRIES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_pc,
  output logic          pred_valid,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target,
  input  logic          upd_valid,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_taken,
  input  logic          upd_is_jump,
  input  logic [AW-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = AW - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [AW-1:0]      tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];

  logic [IDX_W-1:0] lu_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [TAG_W-1:0] upd_tag;
  logic             lu_taken;
  logic             upd_hit;
  logic             upd_we;
  ctr_t             ctr_cur;
  ctr_t             ctr_nxt;
  bp_update_t       upd;

  assign lu_idx  = lu_pc[IDX_W+1:2];
  assign lu_tag  = lu_pc[AW-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[AW-1:IDX_W+2];

  assign upd = '{valid: upd_valid, taken: upd_taken, is_jump: upd_is_jump};

  assign lu_taken = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag) && ctr_q[lu_idx][1];
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // A fresh allocation steps from weak-NT, landing on weak-T (or strong-T for jumps).
  assign ctr_cur = upd_hit ? ctr_q[upd_idx] : CTR_WNT;
  assign upd_we  = upd.valid && (upd_hit || upd.taken);

  sat_ctr2 u_sat_ctr2 (
    .ctr          (ctr_cur),
    .taken        (upd.taken),
    .force_strong (upd.is_jump),
    .ctr_nxt      (ctr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lu_valid;
      pred_taken  <= lu_valid && lu_taken;
      pred_target <= (lu_valid && lu_taken) ? tgt_q[lu_idx] : '0;
    end
  end

  // Lookup reads the pre-update table, so a same-index update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      ctr_q[upd_idx]   <= ctr_nxt;
      if (upd.taken) tgt_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

  localparam int AW      = 32;
  localparam int ENTRIES = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lu_valid = 1'b0;
  logic [AW-1:0] lu_pc = '0;
  logic          pred_valid;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          upd_valid = 1'b0;
  logic [AW-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic          upd_is_jump = 1'b0;
  logic [AW-1:0] upd_target = '0;

  typedef struct packed {
    logic          v;
    logic          t;
    logic [AW-1:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.AW(AW), .ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lu_valid    (lu_valid),
    .lu_pc       (lu_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_is_jump (upd_is_jump),
    .upd_target  (upd_target)
  );

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic lv, input logic [AW-1:0] lpc,
                      input logic uv, input logic [AW-1:0] upc,
                      input logic ut, input logic uj, input logic [AW-1:0] utgt,
                      input logic et, input logic [AW-1:0] etgt);
    exp_t e;
    lu_valid    = lv;
    lu_pc       = lpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_is_jump = uj;
    upd_target  = utgt;
    exp_q.push_back('{v: lv, t: et, tgt: etgt});
    @(posedge clk);
    #1;
    lu_valid  = 1'b0;
    upd_valid = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".valid"},  AW'(pred_valid), AW'(e.v));
    check({tag, ".taken"},  AW'(pred_taken), AW'(e.t));
    check({tag, ".target"}, pred_target,     e.tgt);
  endtask

  task automatic upd(input string tag, input logic [AW-1:0] pc, input logic t, input logic j,
                     input logic [AW-1:0] tgt);
    step(tag, 1'b0, '0, 1'b1, pc, t, j, tgt, 1'b0, '0);
  endtask

  task automatic look(input string tag, input logic [AW-1:0] pc, input logic et,
                      input logic [AW-1:0] etgt);
    step(tag, 1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0, et, etgt);
  endtask

  initial begin
    @(posedge clk);
    #1;
    check("rst.valid",  AW'(pred_valid), '0);
    check("rst.taken",  AW'(pred_taken), '0);
    check("rst.target", pred_target,     '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Build state, then assert reset mid-cycle with a lookup and an update in flight.
    upd("pre.alloc", 32'h100, 1'b1, 1'b0, 32'h200);
    look("pre.look", 32'h100, 1'b1, 32'h200);
    lu_valid = 1'b1; lu_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1; upd_is_jump = 1'b0; upd_target = 32'h999;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.valid_async", AW'(pred_valid), '0);
    @(posedge clk);
    #1;
    check("midrst.valid", AW'(pred_valid), '0);
    check("midrst.taken", AW'(pred_taken), '0);
    lu_valid = 1'b0; upd_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    look("postrst.100", 32'h100, 1'b0, '0);
    look("postrst.140", 32'h140, 1'b0, '0);

    // Same-cycle collision doubles as allocate-on-taken.
    step("coll.same", 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, '0);
    look("coll.next", 32'h100, 1'b1, 32'h200);

    // Hysteresis from weak-T.
    upd("hys.nt1", 32'h100, 1'b0, 1'b0, 32'h0);
    look("hys.l1", 32'h100, 1'b0, '0);
    upd("hys.nt2", 32'h100, 1'b0, 1'b0, 32'h0);
    look("hys.l2", 32'h100, 1'b0, '0);
    upd("hys.nt3", 32'h100, 1'b0, 1'b0, 32'h0);
    look("hys.l3", 32'h100, 1'b0, '0);
    upd("hys.t1", 32'h100, 1'b1, 1'b0, 32'h200);
    look("hys.l4", 32'h100, 1'b0, '0);
    upd("hys.t2", 32'h100, 1'b1, 1'b0, 32'h200);
    look("hys.l5", 32'h100, 1'b1, 32'h200);

    // Saturation at strong-T, then jump allocate and force-strong on hit.
    for (int i = 0; i < 5; i++) upd("sat.t", 32'h300, 1'b1, 1'b0, 32'h400);
    look("sat.l1", 32'h300, 1'b1, 32'h400);
    upd("sat.nt", 32'h300, 1'b0, 1'b0, 32'h0);
    look("sat.l2", 32'h300, 1'b1, 32'h400);
    upd("jmp.alloc", 32'h500, 1'b1, 1'b1, 32'h600);
    look("jmp.l1", 32'h500, 1'b1, 32'h600);
    upd("jmp.nt1", 32'h500, 1'b0, 1'b0, 32'h0);
    look("jmp.l2", 32'h500, 1'b1, 32'h600);
    upd("jmp.nt2", 32'h500, 1'b0, 1'b0, 32'h0);
    look("jmp.l3", 32'h500, 1'b0, '0);
    upd("jmp.hit", 32'h500, 1'b1, 1'b1, 32'h680);
    upd("jmp.nt3", 32'h500, 1'b0, 1'b0, 32'h0);
    look("jmp.l4", 32'h500, 1'b1, 32'h680);

    // Aliasing on index 0.
    upd("alias.a", 32'h100, 1'b1, 1'b0, 32'h200);
    upd("alias.b", 32'h200, 1'b1, 1'b0, 32'h900);
    look("alias.l100", 32'h100, 1'b0, '0);
    look("alias.l200", 32'h200, 1'b1, 32'h900);
    look("alias.lowbits", 32'h202, 1'b1, 32'h900);

    // Target rewrite only on taken hits; not-taken miss does not allocate.
    upd("tgt.t", 32'h200, 1'b1, 1'b0, 32'hA00);
    upd("tgt.nt", 32'h200, 1'b0, 1'b0, 32'hBBB);
    look("tgt.l", 32'h200, 1'b1, 32'hA00);
    upd("miss.nt", 32'h140, 1'b0, 1'b0, 32'h777);
    look("miss.l", 32'h140, 1'b0, '0);
    step("idle", 1'b0, 32'h200, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
